// File: rtl/fp_solver_axil_pkg.sv
// Shared register-map constants and helpers for the fp solver AXI4-Lite control block.
package fp_solver_axil_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned STRB_W     = DATA_W / 8;
   localparam int unsigned WORD_IDX_W = 2;

   localparam logic [WORD_IDX_W-1:0] ADDR_OPA    = 2'd0;
   localparam logic [WORD_IDX_W-1:0] ADDR_OPB    = 2'd1;
   localparam logic [WORD_IDX_W-1:0] ADDR_CTRL   = 2'd2;
   localparam logic [WORD_IDX_W-1:0] ADDR_RESULT = 2'd3;

   localparam int unsigned CTRL_START_BIT    = 0;
   localparam int unsigned CTRL_DONE_CLR_BIT = 1;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Byte-lane merge of new write data into an existing register value.
   function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] new_val,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] r;
      r = old_val;
      for (int i = 0; i < int'(STRB_W); i++) begin
         if (strb[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/fp_solver_axil_ctrl.sv
// AXI4-Lite register block for the fp equation solver core: operands, start/busy/done
// control and result capture.
module fp_solver_axil_ctrl
   import fp_solver_axil_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   core_op_a,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   core_op_b,
   output logic                            core_start,
   input  logic                            core_done,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   core_result
);

   logic                  aw_full;
   logic [WORD_IDX_W-1:0] aw_idx;
   logic                  w_full;
   logic [DATA_W-1:0]     w_data;
   logic [STRB_W-1:0]     w_strb;
   logic [DATA_W-1:0]     result;
   logic                  busy;
   logic                  done;

   logic                  commit;
   logic                  wr_ctrl;
   logic                  start_ok;
   logic                  done_clr;
   logic [WORD_IDX_W-1:0] ar_idx;
   logic [DATA_W-1:0]     rd_mux;
   logic                  unused_sink;

   assign S_AXI_BRESP = RESP_OKAY;
   assign S_AXI_RRESP = RESP_OKAY;
   assign unused_sink = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // A write commits once both address and data latches hold their beats.
   assign commit   = aw_full && w_full;
   assign wr_ctrl  = commit && (aw_idx == ADDR_CTRL);
   assign start_ok = wr_ctrl && w_data[CTRL_START_BIT] && !busy && !core_done;
   assign done_clr = wr_ctrl && w_data[CTRL_DONE_CLR_BIT];
   assign ar_idx   = S_AXI_ARADDR[WORD_IDX_W+1:2];

   // Read-data source, sampled from pre-commit register state.
   always_comb begin
      rd_mux = '0;
      case (ar_idx)
         ADDR_OPA:    rd_mux = core_op_a;
         ADDR_OPB:    rd_mux = core_op_b;
         ADDR_CTRL:   rd_mux = DATA_W'({done, busy});
         ADDR_RESULT: rd_mux = result;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         aw_full       <= 1'b0;
         aw_idx        <= '0;
         w_full        <= 1'b0;
         w_data        <= '0;
         w_strb        <= '0;
         core_op_a     <= '0;
         core_op_b     <= '0;
         result        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         core_start    <= 1'b0;
      end else begin
         S_AXI_AWREADY <= S_AXI_AWVALID && !S_AXI_AWREADY && !aw_full && !S_AXI_BVALID;
         S_AXI_WREADY  <= S_AXI_WVALID && !S_AXI_WREADY && !w_full && !S_AXI_BVALID;

         if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_full <= 1'b1;
            aw_idx  <= S_AXI_AWADDR[WORD_IDX_W+1:2];
         end
         if (S_AXI_WVALID && S_AXI_WREADY) begin
            w_full <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end

         if (commit) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            if (aw_idx == ADDR_OPA) core_op_a <= apply_wstrb(core_op_a, w_data, w_strb);
            if (aw_idx == ADDR_OPB) core_op_b <= apply_wstrb(core_op_b, w_data, w_strb);
         end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end

         // Core completion takes priority over both START and DONE-clear.
         core_start <= start_ok;
         if (core_done) begin
            result <= core_result;
            done   <= 1'b1;
            busy   <= 1'b0;
         end else begin
            if (start_ok) begin
               busy <= 1'b1;
               done <= 1'b0;
            end
            if (done_clr) done <= 1'b0;
         end

         S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID;
         if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_mux;
         end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fp_solver_axil_ctrl.sv
// Self-checking bench for fp_solver_axil_ctrl: directed register-map scenarios followed by
// randomized AXI traffic compared against a register-level model.
module tb_fp_solver_axil_ctrl;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [3:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] core_op_a;
   logic [31:0] core_op_b;
   logic        core_start;
   logic        core_done;
   logic [31:0] core_result;

   int n_vec = 0;
   int n_err = 0;
   int start_cnt = 0;

   // Reference model state
   logic [31:0] m_opa, m_opb, m_result;
   logic        m_busy, m_done;
   int          exp_starts;

   fp_solver_axil_ctrl dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESETN(aresetn),
      .S_AXI_AWADDR (awaddr),
      .S_AXI_AWPROT (awprot),
      .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA  (wdata),
      .S_AXI_WSTRB  (wstrb),
      .S_AXI_WVALID (wvalid),
      .S_AXI_WREADY (wready),
      .S_AXI_BRESP  (bresp),
      .S_AXI_BVALID (bvalid),
      .S_AXI_BREADY (bready),
      .S_AXI_ARADDR (araddr),
      .S_AXI_ARPROT (arprot),
      .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA  (rdata),
      .S_AXI_RRESP  (rresp),
      .S_AXI_RVALID (rvalid),
      .S_AXI_RREADY (rready),
      .core_op_a    (core_op_a),
      .core_op_b    (core_op_b),
      .core_start   (core_start),
      .core_done    (core_done),
      .core_result  (core_result)
   );

   always #5 clk = ~clk;

   // Count every cycle in which the launch pulse is high.
   always @(negedge clk) if (core_start) start_cnt <= start_cnt + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_opa = '0; m_opb = '0; m_result = '0; m_busy = 1'b0; m_done = 1'b0;
   endtask

   function automatic logic [31:0] byte_mask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   task automatic model_write(input logic [3:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic done_co, input logic [31:0] res);
      logic [31:0] mk;
      mk = byte_mask(strb);
      if (done_co) begin
         m_result = res; m_busy = 1'b0; m_done = 1'b1;
      end
      case (addr[3:2])
         2'd0: m_opa = (m_opa & ~mk) | (data & mk);
         2'd1: m_opb = (m_opb & ~mk) | (data & mk);
         2'd2: if (!done_co) begin
                  if (data[0] && !m_busy) begin
                     m_busy = 1'b1; m_done = 1'b0; exp_starts++;
                  end
                  if (data[1]) m_done = 1'b0;
               end
         default: ;
      endcase
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] addr);
      case (addr[3:2])
         2'd0:    return m_opa;
         2'd1:    return m_opb;
         2'd2:    return {30'b0, m_done, m_busy};
         default: return m_result;
      endcase
   endfunction

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic done_co, input logic [31:0] res);
      int t;
      logic aw_go, w_go, aw_done, w_done, held;
      aw_go = 0; w_go = 0; aw_done = 0; w_done = 0; t = 0;
      awaddr = addr; wdata = data; wstrb = strb;
      while (!(aw_done && w_done) && t < 100) begin
         @(negedge clk);
         if (aw_go) begin awvalid = 0; aw_done = 1; aw_go = 0; end
         if (w_go)  begin wvalid = 0;  w_done = 1;  w_go = 0;  end
         if (!aw_done && t >= aw_dly) awvalid = 1;
         if (!w_done && t >= w_dly)   wvalid = 1;
         if (awvalid && awready) aw_go = 1;
         if (wvalid && wready)   w_go = 1;
         t++;
      end
      awvalid = 0; wvalid = 0;
      check_eq("wr_handshake", {31'b0, aw_done && w_done}, 32'd1);
      // The current cycle is the commit cycle: optionally collide a core completion with it.
      if (done_co) begin core_result = res; core_done = 1; end
      t = 0;
      do begin @(negedge clk); core_done = 0; t++; end while (!bvalid && t < 50);
      check_eq("bvalid_seen", {31'b0, bvalid}, 32'd1);
      check_eq("bresp", {30'b0, bresp}, 32'd0);
      held = 1;
      for (int i = 0; i < b_dly; i++) begin
         @(negedge clk);
         if (bvalid !== 1'b1) held = 0;
      end
      check_eq("bvalid_hold", {31'b0, held}, 32'd1);
      bready = 1;
      @(negedge clk);
      bready = 0;
      check_eq("bvalid_drop", {31'b0, bvalid}, 32'd0);
      model_write(addr, data, strb, done_co, res);
   endtask

   task automatic axi_read(input logic [3:0] addr, input int r_dly, output logic [31:0] data);
      int t;
      logic [31:0] first;
      logic stable;
      @(negedge clk);
      araddr = addr; arvalid = 1;
      t = 0;
      while (!arready && t < 50) begin @(negedge clk); t++; end
      check_eq("arready_seen", {31'b0, arready}, 32'd1);
      @(negedge clk);
      arvalid = 0;
      t = 0;
      while (!rvalid && t < 50) begin @(negedge clk); t++; end
      check_eq("rvalid_seen", {31'b0, rvalid}, 32'd1);
      first = rdata; stable = 1;
      for (int i = 0; i < r_dly; i++) begin
         @(negedge clk);
         if (rdata !== first || rvalid !== 1'b1) stable = 0;
      end
      check_eq("rdata_hold", {31'b0, stable}, 32'd1);
      check_eq("rresp", {30'b0, rresp}, 32'd0);
      rready = 1;
      @(negedge clk);
      rready = 0;
      check_eq("rvalid_drop", {31'b0, rvalid}, 32'd0);
      data = first;
   endtask

   task automatic pulse_done(input logic [31:0] res);
      @(negedge clk);
      core_result = res; core_done = 1;
      @(negedge clk);
      core_done = 0;
      m_result = res; m_busy = 1'b0; m_done = 1'b1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      aresetn = 0;
      repeat (3) @(negedge clk);
      aresetn = 1;
      model_reset();
   endtask

   initial begin
      logic [31:0] rd;
      logic [3:0]  a;
      int          s0, t;
      aresetn = 0; awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
      bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;
      core_done = 0; core_result = '0; exp_starts = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("rst_awready", {31'b0, awready}, 32'd0);
      check_eq("rst_wready",  {31'b0, wready},  32'd0);
      check_eq("rst_bvalid",  {31'b0, bvalid},  32'd0);
      check_eq("rst_arready", {31'b0, arready}, 32'd0);
      check_eq("rst_rvalid",  {31'b0, rvalid},  32'd0);
      check_eq("rst_rdata",   rdata,            32'd0);
      check_eq("rst_start",   {31'b0, core_start}, 32'd0);
      check_eq("rst_op_a",    core_op_a,        32'd0);
      aresetn = 1;

      // Operand write/read-back
      axi_write(4'h0, 32'h3F800000, 4'hF, 0, 0, 0, 0, 0);
      axi_write(4'h4, 32'h40000000, 4'hF, 1, 0, 1, 0, 0);
      axi_read(4'h0, 0, rd); check_eq("t1_opa", rd, 32'h3F800000);
      axi_read(4'h4, 2, rd); check_eq("t1_opb", rd, 32'h40000000);
      check_eq("t1_core_op_b", core_op_b, 32'h40000000);

      // Partial strobe
      axi_write(4'h0, 32'h00000000, 4'hF, 0, 0, 0, 0, 0);
      axi_write(4'h0, 32'hFFFFFFFF, 4'b0011, 0, 0, 0, 0, 0);
      axi_read(4'h0, 0, rd); check_eq("t2_strb", rd, 32'h0000FFFF);

      // Start, then start while busy
      s0 = start_cnt;
      axi_write(4'h8, 32'h1, 4'hF, 0, 0, 0, 0, 0);
      check_eq("t3_one_pulse", 32'(start_cnt - s0), 32'd1);
      axi_read(4'h8, 0, rd); check_eq("t3_ctrl_busy", rd, 32'h1);
      s0 = start_cnt;
      axi_write(4'h8, 32'h1, 4'hF, 0, 0, 0, 0, 0);
      check_eq("t3_no_pulse", 32'(start_cnt - s0), 32'd0);

      // Completion capture and DONE clear
      pulse_done(32'h40400000);
      axi_read(4'hC, 0, rd); check_eq("t4_result", rd, 32'h40400000);
      axi_read(4'h8, 0, rd); check_eq("t4_ctrl_done", rd, 32'h2);
      axi_write(4'h8, 32'h2, 4'hF, 0, 0, 0, 0, 0);
      axi_read(4'h8, 0, rd); check_eq("t4_ctrl_clr", rd, 32'h0);
      axi_write(4'hC, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
      axi_read(4'hC, 0, rd); check_eq("t4_result_ro", rd, 32'h40400000);

      // Skewed AW/W with stalled BREADY
      axi_write(4'h4, 32'h12345678, 4'hF, 0, 3, 4, 0, 0);
      axi_read(4'h4, 0, rd); check_eq("t5_opb", rd, 32'h12345678);

      // core_done collides with DONE-clear commit
      axi_write(4'h8, 32'h1, 4'hF, 0, 0, 0, 0, 0);
      axi_write(4'h8, 32'h2, 4'hF, 0, 0, 0, 1, 32'h41000000);
      axi_read(4'h8, 0, rd); check_eq("t6_set_wins", rd, 32'h2);
      axi_read(4'hC, 0, rd); check_eq("t6_result", rd, 32'h41000000);
      // START and clear together: START applies, DONE ends at 0
      s0 = start_cnt;
      axi_write(4'h8, 32'h3, 4'hF, 0, 0, 0, 0, 0);
      check_eq("t6_start_clr_pulse", 32'(start_cnt - s0), 32'd1);
      axi_read(4'h8, 0, rd); check_eq("t6_start_clr", rd, 32'h1);

      // Randomized traffic against the model
      for (int n = 0; n < 80; n++) begin
         a = {2'($urandom_range(0, 3)), 2'b00};
         case ($urandom_range(0, 5))
            0, 1: axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
            2:    axi_write(4'h8, 32'($urandom_range(0, 3)), 4'hF, $urandom_range(0, 2),
                            $urandom_range(0, 2), $urandom_range(0, 2), 0, 0);
            3:    pulse_done($urandom);
            default: begin
               axi_read(a, $urandom_range(0, 3), rd);
               check_eq("rnd_read", rd, model_read(a));
            end
         endcase
         check_eq("rnd_starts", 32'(start_cnt), 32'(exp_starts));
         check_eq("rnd_op_a", core_op_a, m_opa);
      end

      // Reset while a read response is pending
      @(negedge clk);
      araddr = 4'h0; arvalid = 1;
      t = 0;
      while (!arready && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      arvalid = 0;
      check_eq("t6_rvalid_pending", {31'b0, rvalid}, 32'd1);
      aresetn = 0;
      @(negedge clk);
      check_eq("t6_rst_rvalid", {31'b0, rvalid}, 32'd0);
      repeat (2) @(negedge clk);
      aresetn = 1;
      model_reset();
      axi_read(4'h8, 0, rd); check_eq("post_rst_ctrl", rd, 32'h0);
      axi_read(4'h0, 0, rd); check_eq("post_rst_opa", rd, 32'h0);
      axi_read(4'hC, 0, rd); check_eq("post_rst_result", rd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
